// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A holds the partial remainder, B the dividend that becomes the quotient, D the divisor.
module restoring_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             CLR_LDB,
    input  logic [WIDTH-1:0] Switches,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             Busy,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;
    logic             busy_reg;
    logic             div_zero;

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   trial;
    logic             last_iter;

    // The bit shifted out of A must take part in the compare, so the
    // shifted remainder and the trial difference are WIDTH+1 bits wide.
    always_comb begin
        a_ext     = {a_reg, b_reg[WIDTH-1]};
        trial     = a_ext - {1'b0, d_reg};
        last_iter = (count == CW'(WIDTH - 1));
    end

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!Run) begin
                    state_next = (Switches == '0) ? HOLD : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (Run) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
        end else begin
            state    <= state_next;
            busy_reg <= (state_next == CALC);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            d_reg    <= '0;
            count    <= '0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!Run) begin
                        if (Switches != '0) begin
                            d_reg    <= Switches;
                            a_reg    <= '0;
                            count    <= '0;
                            div_zero <= 1'b0;
                        end else begin
                            // Divide by zero: all-ones quotient, dividend reported as remainder.
                            b_reg    <= '1;
                            a_reg    <= b_reg;
                            div_zero <= 1'b1;
                        end
                    end else if (!CLR_LDB) begin
                        b_reg <= Switches;
                        a_reg <= '0;
                    end
                end
                CALC: begin
                    a_reg <= trial[WIDTH] ? a_ext[WIDTH-1:0] : trial[WIDTH-1:0];
                    b_reg <= {b_reg[WIDTH-2:0], ~trial[WIDTH]};
                    count <= count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign A_out   = a_reg;
    assign B_out   = b_reg;
    assign Busy    = busy_reg;
    assign DivZero = div_zero;

endmodule
